// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer for one matrix-PE dot product.
// Issues SRAM beats, aligns accumulator enables, hands the result out.
module pe_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_neuron_base,
    input  logic [ADDR_W-1:0] cfg_weight_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] neuron_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              acc_en,
    output logic              acc_first,
    output logic              result_vld,
    input  logic              result_rdy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  iss_q, iss_d;
    logic [LEN_W-1:0]  ret_q, ret_d;
    logic [ADDR_W-1:0] naddr_q, naddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_fst_q, rd_fst_d;
    logic [PIPE_LAT-1:0] pv_q, pv_d;
    logic [PIPE_LAT-1:0] pf_q, pf_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic              empty_st;
    logic              acc_tail;

    assign acc_tail = pv_q[PIPE_LAT-1];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        iss_d    = iss_q;
        ret_d    = ret_q;
        naddr_d  = naddr_q;
        waddr_d  = waddr_q;
        rd_en_d  = 1'b0;
        rd_fst_d = 1'b0;
        done_d   = 1'b0;
        empty_st = 1'b0;

        if (acc_tail) begin
            ret_d = ret_q + LEN_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    naddr_d = cfg_neuron_base;
                    waddr_d = cfg_weight_base;
                    ret_d   = '0;
                    if (cfg_len != '0) begin
                        state_d  = S_ISSUE;
                        rd_en_d  = 1'b1;
                        rd_fst_d = 1'b1;
                        iss_d    = LEN_W'(1);
                    end else begin
                        // Empty op: a lone acc_first clears the accumulator
                        state_d  = S_DRAIN;
                        empty_st = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (iss_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    naddr_d = naddr_q + ADDR_W'(1);
                    waddr_d = waddr_q + ADDR_W'(1);
                    iss_d   = iss_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if ((len_q == '0) ||
                    (acc_tail && (ret_q + LEN_W'(1) == len_q))) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (vld_q && result_rdy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        vld_d  = (state_d == S_OUT);
    end

    always_comb begin
        pv_d    = '0;
        pf_d    = '0;
        pv_d[0] = rd_en_q;
        pf_d[0] = rd_fst_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pf_d[i] = pf_q[i-1];
        end
        pf_d[PIPE_LAT-1] = pf_d[PIPE_LAT-1] | empty_st;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            iss_q    <= '0;
            ret_q    <= '0;
            naddr_q  <= '0;
            waddr_q  <= '0;
            rd_en_q  <= 1'b0;
            rd_fst_q <= 1'b0;
            pv_q     <= '0;
            pf_q     <= '0;
            busy_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            iss_q    <= iss_d;
            ret_q    <= ret_d;
            naddr_q  <= naddr_d;
            waddr_q  <= waddr_d;
            rd_en_q  <= rd_en_d;
            rd_fst_q <= rd_fst_d;
            pv_q     <= pv_d;
            pf_q     <= pf_d;
            busy_q   <= busy_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign rd_en       = rd_en_q;
    assign neuron_addr = naddr_q;
    assign weight_addr = waddr_q;
    assign acc_en      = pv_q[PIPE_LAT-1];
    assign acc_first   = pf_q[PIPE_LAT-1];
    assign result_vld  = vld_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: scoreboard bench for pe_ctrl.
// Read/accumulate beats are queued at start and popped as the DUT emits them.
module tb_pe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cfg_neuron_base;
    logic [9:0] cfg_weight_base;
    logic [9:0] cfg_len;
    logic       busy;
    logic       rd_en;
    logic [9:0] neuron_addr;
    logic [9:0] weight_addr;
    logic       acc_en;
    logic       acc_first;
    logic       result_vld;
    logic       result_rdy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [19:0] rd_q[$];
    logic        acc_q[$];
    int          pend_done = 0;

    logic [31:0] rd_m, acc_m, fst_m, vld_m, dn_m, bsy_m;
    logic [19:0] e_rd;
    logic        e_fst;

    pe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_neuron_base(cfg_neuron_base),
        .cfg_weight_base(cfg_weight_base),
        .cfg_len        (cfg_len),
        .busy           (busy),
        .rd_en          (rd_en),
        .neuron_addr    (neuron_addr),
        .weight_addr    (weight_addr),
        .acc_en         (acc_en),
        .acc_first      (acc_first),
        .result_vld     (result_vld),
        .result_rdy     (result_rdy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("rd_extra", 32'd1, 32'd0);
            end else begin
                e_rd = rd_q.pop_front();
                chk("rd_addr", {12'd0, neuron_addr, weight_addr},
                    {12'd0, e_rd});
            end
        end
        if (acc_en === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("acc_extra", 32'd1, 32'd0);
            end else begin
                e_fst = acc_q.pop_front();
                chk("acc_first", {31'd0, acc_first}, {31'd0, e_fst});
            end
        end
        if (done === 1'b1) begin
            if (pend_done == 0) chk("done_extra", 32'd1, 32'd0);
            else pend_done--;
        end
    end

    task automatic push_op(input logic [9:0] nb, input logic [9:0] wb,
                           input int len);
        logic [9:0] n, w;
        for (int k = 0; k < len; k++) begin
            n = nb + 10'(k);
            w = wb + 10'(k);
            rd_q.push_back({n, w});
            acc_q.push_back(k == 0);
        end
        pend_done++;
    endtask

    task automatic start_op(input logic [9:0] nb, input logic [9:0] wb,
                            input int len, input bit hold);
        @(posedge clk); #1;
        start           = 1'b1;
        cfg_neuron_base = nb;
        cfg_weight_base = wb;
        cfg_len         = 10'(len);
        push_op(nb, wb, len);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic trace(input int n, input int drop);
        rd_m = '0; acc_m = '0; fst_m = '0;
        vld_m = '0; dn_m = '0; bsy_m = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            rd_m[c]  = rd_en;
            acc_m[c] = acc_en;
            fst_m[c] = acc_first;
            vld_m[c] = result_vld;
            dn_m[c]  = done;
            bsy_m[c] = busy;
            if (c == drop) start = 1'b0;
        end
    endtask

    task automatic chk_masks(input string t, input logic [31:0] rd,
                             input logic [31:0] ac, input logic [31:0] fs,
                             input logic [31:0] vl, input logic [31:0] dn,
                             input logic [31:0] bs);
        chk({t, "_rd"}, rd_m, rd);
        chk({t, "_acc"}, acc_m, ac);
        chk({t, "_fst"}, fst_m, fs);
        chk({t, "_vld"}, vld_m, vl);
        chk({t, "_done"}, dn_m, dn);
        chk({t, "_busy"}, bsy_m, bs);
    endtask

    task automatic op_len4();
        result_rdy = 1'b1;
        start_op(10'h010, 10'h200, 4, 1'b0);
        trace(10, 0);
        chk_masks("len4", 32'h1E, 32'h78, 32'h08, 32'h80, 32'h100, 32'hFE);
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b1;
        cfg_neuron_base = 10'h123;
        cfg_weight_base = 10'h321;
        cfg_len         = 10'd3;
        result_rdy      = 1'b1;

        // reset held two cycles with start asserted
        repeat (2) begin
            @(negedge clk);
            chk("reset_out", {10'd0, busy, rd_en, acc_en, acc_first,
                              result_vld, done, neuron_addr, weight_addr},
                32'd0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {30'd0, busy, rd_en}, 32'd0);

        op_len4();

        // wrap and result back-pressure
        result_rdy = 1'b0;
        start_op(10'h3FE, 10'h100, 3, 1'b0);
        trace(10, 0);
        chk_masks("wrap", 32'h0E, 32'h38, 32'h08, 32'h7C0, 32'h0, 32'h7FE);
        result_rdy = 1'b1;
        @(negedge clk);
        chk("wrap_hs", {30'd0, done, result_vld}, 32'h2);
        @(negedge clk);
        chk("wrap_idle", {31'd0, busy}, 32'd0);

        // empty operation
        start_op(10'h005, 10'h006, 0, 1'b0);
        trace(5, 0);
        chk_masks("empty", 32'h0, 32'h0, 32'h2, 32'h4, 32'h8, 32'h6);

        // start held with other cfg during op; accepted on the done cycle
        start_op(10'h040, 10'h080, 5, 1'b1);
        cfg_neuron_base = 10'h155;
        cfg_weight_base = 10'h2AA;
        cfg_len         = 10'd2;
        push_op(10'h155, 10'h2AA, 2);
        trace(16, 10);
        chk_masks("b2b", 32'hC3E, 32'h30F8, 32'h1008, 32'h4100,
                  32'h8200, 32'h7DFE);

        // reset in the middle of ISSUE
        start_op(10'h0A0, 10'h1A0, 6, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rd_q.delete();
        acc_q.delete();
        pend_done = 0;
        @(negedge clk);
        chk("mid_rst", {26'd0, busy, rd_en, acc_en, acc_first,
                        result_vld, done}, 32'd0);
        rst_n = 1'b1;
        trace(6, 0);
        chk("abort_done", dn_m, 32'd0);
        chk("abort_rd", rd_m, 32'd0);
        chk("abort_busy", bsy_m, 32'd0);

        op_len4();

        repeat (3) @(negedge clk);
        chk("rd_q_left", rd_q.size(), 32'd0);
        chk("acc_q_left", acc_q.size(), 32'd0);
        chk("done_left", pend_done, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
